// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: states, opcodes, mux-select encodings and the control word for the multicycle MIPS controller
package mips_ctrl_pkg;
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP
  } state_e;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BTA  = 2'b11;
  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  typedef struct packed {
    logic       mem_req;
    logic       pcwrite;
    logic       pcwrite_cond;
    logic       irwrite;
    logic       memwrite;
    logic       regwrite;
    logic       iord;
    logic       alusrca;
    logic       regdst;
    logic       memtoreg;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
  } ctrl_t;
endpackage

// File: rtl/ctrl_out_dec.sv
// ctrl_out_dec: state-to-control-word decode; strobes that complete a memory access are qualified by mem_ready
//   state_i     current controller state
//   mem_ready_i memory access complete this cycle
//   ctrl_o      datapath control word
module ctrl_out_dec
  import mips_ctrl_pkg::*;
(
  input  state_e state_i,
  input  logic   mem_ready_i,
  output ctrl_t  ctrl_o
);
  always_comb begin
    ctrl_o = '0;
    case (state_i)
      FETCH: begin
        ctrl_o.mem_req = 1'b1;
        ctrl_o.alusrcb = SRCB_FOUR;
        ctrl_o.irwrite = mem_ready_i;
        ctrl_o.pcwrite = mem_ready_i;
      end
      DECODE: ctrl_o.alusrcb = SRCB_BTA;
      MEMADR: begin
        ctrl_o.alusrca = 1'b1;
        ctrl_o.alusrcb = SRCB_IMM;
      end
      MEMRD: begin
        ctrl_o.mem_req = 1'b1;
        ctrl_o.iord    = 1'b1;
      end
      MEMWB: begin
        ctrl_o.regwrite = 1'b1;
        ctrl_o.memtoreg = 1'b1;
      end
      MEMWR: begin
        ctrl_o.mem_req  = 1'b1;
        ctrl_o.iord     = 1'b1;
        ctrl_o.memwrite = mem_ready_i;
      end
      EXEC: begin
        ctrl_o.alusrca = 1'b1;
        ctrl_o.alusrcb = SRCB_REG;
        ctrl_o.aluop   = ALU_FUNCT;
      end
      ALUWB: begin
        ctrl_o.regwrite = 1'b1;
        ctrl_o.regdst   = 1'b1;
      end
      BRANCH: begin
        ctrl_o.alusrca      = 1'b1;
        ctrl_o.aluop        = ALU_SUB;
        ctrl_o.pcsrc        = PC_ALUOUT;
        ctrl_o.pcwrite_cond = 1'b1;
      end
      ADDIEX: begin
        ctrl_o.alusrca = 1'b1;
        ctrl_o.alusrcb = SRCB_IMM;
        ctrl_o.aluop   = ALU_ADD;
      end
      ADDIWB: ctrl_o.regwrite = 1'b1;
      JUMP: begin
        ctrl_o.pcwrite = 1'b1;
        ctrl_o.pcsrc   = PC_JUMP;
      end
      default: ctrl_o = '0;
    endcase
  end
endmodule

// File: rtl/control_fsm.sv
// control_fsm: multicycle MIPS Moore controller (fetch/decode/execute sequencing with memory wait states)
//   clk, rst (sync, active high), op (opcode from IR), mem_ready (memory access done)
//   mem_req, write enables, mux selects, aluop, illegal (undefined-opcode pulse)
//   BNE_EN: adds bne decode and the branch_ne output
module control_fsm
  import mips_ctrl_pkg::*;
#(
  parameter int OPW = 6
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [OPW-1:0] op,
  input  logic           mem_ready,
  output logic           mem_req,
  output logic           pcwrite,
  output logic           pcwrite_cond,
  output logic           irwrite,
  output logic           memwrite,
  output logic           regwrite,
  output logic           iord,
  output logic           alusrca,
  output logic           regdst,
  output logic           memtoreg,
  output logic [1:0]     alusrcb,
  output logic [1:0]     pcsrc,
  output logic [1:0]     aluop,
`ifdef BNE_EN
  output logic           branch_ne,
`endif
  output logic           illegal
);
  state_e state_q, state_d;
  logic   blank_q;
  ctrl_t  ctrl, ctrl_gated;
  logic   is_lw, is_sw, is_r, is_beq, is_addi, is_j, is_bne, legal;
  assign is_lw   = op == OPW'(OP_LW);
  assign is_sw   = op == OPW'(OP_SW);
  assign is_r    = op == OPW'(OP_RTYPE);
  assign is_beq  = op == OPW'(OP_BEQ);
  assign is_addi = op == OPW'(OP_ADDI);
  assign is_j    = op == OPW'(OP_J);
`ifdef BNE_EN
  assign is_bne  = op == OPW'(OP_BNE);
`else
  assign is_bne  = 1'b0;
`endif
  assign legal = is_lw | is_sw | is_r | is_beq | is_bne | is_addi | is_j;
  // blank_q holds outputs at zero (and the FSM in FETCH) for the first cycle after any reset edge
  always_comb begin
    state_d = state_q;
    if (!blank_q)
      case (state_q)
        FETCH:   state_d = mem_ready ? DECODE : FETCH;
        DECODE:  state_d = (is_lw | is_sw) ? MEMADR :
                           is_r ? EXEC :
                           (is_beq | is_bne) ? BRANCH :
                           is_addi ? ADDIEX :
                           is_j ? JUMP : FETCH;
        MEMADR:  state_d = is_sw ? MEMWR : MEMRD;
        MEMRD:   state_d = mem_ready ? MEMWB : MEMRD;
        MEMWR:   state_d = mem_ready ? FETCH : MEMWR;
        EXEC:    state_d = ALUWB;
        ADDIEX:  state_d = ADDIWB;
        default: state_d = FETCH;
      endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      blank_q <= 1'b1;
    end else begin
      state_q <= state_d;
      blank_q <= 1'b0;
    end
  end
  // reset outranks a completing memory access, so no strobe fires in a reset cycle
  ctrl_out_dec u_dec (
    .state_i     (state_q),
    .mem_ready_i (mem_ready & ~rst),
    .ctrl_o      (ctrl)
  );
  assign ctrl_gated = blank_q ? '0 : ctrl;
  assign {mem_req, pcwrite, pcwrite_cond, irwrite, memwrite, regwrite, iord, alusrca, regdst, memtoreg,
          alusrcb, pcsrc, aluop} = ctrl_gated;
  assign illegal = !blank_q && state_q == DECODE && !legal;
`ifdef BNE_EN
  assign branch_ne = !blank_q && state_q == BRANCH && is_bne;
`endif
endmodule

// File: tb/tb_control_fsm.sv
// tb_control_fsm: directed and randomized checks of control_fsm against an instruction-sequence model
module tb_control_fsm;
  typedef struct packed {
    logic       mem_req;
    logic       pcwrite;
    logic       pcwrite_cond;
    logic       irwrite;
    logic       memwrite;
    logic       regwrite;
    logic       iord;
    logic       alusrca;
    logic       regdst;
    logic       memtoreg;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
    logic       illegal;
    logic       bne;
  } o_t;
  typedef int q_t[$];
  localparam int S_F = 0, S_D = 1, S_A = 2, S_RD = 3, S_WB = 4, S_WR = 5, S_EX = 6, S_AW = 7,
                 S_BR = 8, S_IX = 9, S_IW = 10, S_J = 11;
  logic clk = 1'b0, rst = 1'b1, mr = 1'b0;
  logic [5:0] op = 6'd0;
  logic mem_req, pcwrite, pcwrite_cond, irwrite, memwrite, regwrite, iord, alusrca, regdst, memtoreg, illegal, bne_w;
  logic [1:0] alusrcb, pcsrc, aluop;
  o_t dut_o, exp_v;
  int nchk = 0, nerr = 0;
  bit chk_en = 1'b0;
  int m_cur = S_F;
  bit m_z = 1'b1;
  always #5 clk = ~clk;
  control_fsm #(.OPW(6)) dut (
    .clk(clk), .rst(rst), .op(op), .mem_ready(mr),
    .mem_req(mem_req), .pcwrite(pcwrite), .pcwrite_cond(pcwrite_cond), .irwrite(irwrite),
    .memwrite(memwrite), .regwrite(regwrite), .iord(iord), .alusrca(alusrca), .regdst(regdst),
    .memtoreg(memtoreg), .alusrcb(alusrcb), .pcsrc(pcsrc), .aluop(aluop),
`ifdef BNE_EN
    .branch_ne(bne_w),
`endif
    .illegal(illegal)
  );
`ifndef BNE_EN
  assign bne_w = 1'b0;
`endif
  assign dut_o = {mem_req, pcwrite, pcwrite_cond, irwrite, memwrite, regwrite, iord, alusrca, regdst,
                  memtoreg, alusrcb, pcsrc, aluop, illegal, bne_w};
  // full step list of one instruction, starting at fetch; an undefined opcode ends after decode
  function automatic q_t plan(logic [5:0] o);
    q_t s;
    s = {S_F, S_D};
    case (o)
      6'b100011: s = {s, S_A, S_RD, S_WB};
      6'b101011: s = {s, S_A, S_WR};
      6'b000000: s = {s, S_EX, S_AW};
      6'b000100: s = {s, S_BR};
      6'b001000: s = {s, S_IX, S_IW};
      6'b000010: s = {s, S_J};
`ifdef BNE_EN
      6'b000101: s = {s, S_BR};
`endif
      default: ;
    endcase
    return s;
  endfunction
  function automatic int after(int cur, logic [5:0] o);
    q_t s;
    s = plan(o);
    foreach (s[i]) if (s[i] == cur && i + 1 < s.size()) return s[i+1];
    return S_F;
  endfunction
  function automatic o_t exp_o(int s, logic r, logic [5:0] o, bit z);
    o_t e;
    e = '0;
    if (z) return e;
    case (s)
      S_F:  begin e.mem_req = 1; e.alusrcb = 2'b01; e.irwrite = r; e.pcwrite = r; end
      S_D:  begin e.alusrcb = 2'b11; e.illegal = plan(o).size() == 2; end
      S_A:  begin e.alusrca = 1; e.alusrcb = 2'b10; end
      S_RD: begin e.mem_req = 1; e.iord = 1; end
      S_WB: begin e.regwrite = 1; e.memtoreg = 1; end
      S_WR: begin e.mem_req = 1; e.iord = 1; e.memwrite = r; end
      S_EX: begin e.alusrca = 1; e.aluop = 2'b10; end
      S_AW: begin e.regwrite = 1; e.regdst = 1; end
      S_BR: begin
        e.alusrca = 1; e.aluop = 2'b01; e.pcsrc = 2'b01; e.pcwrite_cond = 1;
`ifdef BNE_EN
        e.bne = o == 6'b000101;
`endif
      end
      S_IX: begin e.alusrca = 1; e.alusrcb = 2'b10; end
      S_IW: e.regwrite = 1;
      S_J:  begin e.pcwrite = 1; e.pcsrc = 2'b10; end
      default: ;
    endcase
    return e;
  endfunction
  always @(posedge clk) begin
    if (rst) begin
      m_cur <= S_F;
      m_z   <= 1'b1;
    end else if (m_z) begin
      m_z <= 1'b0;
    end else if (!((m_cur == S_F || m_cur == S_RD || m_cur == S_WR) && !mr)) begin
      m_cur <= after(m_cur, op);
    end
  end
  always @(negedge clk) begin
    if (chk_en) begin
      exp_v = exp_o(m_cur, mr && !rst, op, m_z);
      nchk++;
      if (dut_o !== exp_v) begin
        nerr++;
        $display("FAIL model_cmp t=%0t step=%0d op=%b got=%h want=%h", $time, m_cur, op, dut_o, exp_v);
      end
    end
  end
  task automatic ck(string n, logic [31:0] got, logic [31:0] want);
    nchk++;
    if (got !== want) begin
      nerr++;
      $display("FAIL %s got=%h want=%h", n, got, want);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [5:0] pick();
    logic [5:0] ops[7];
    int r;
    ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010, 6'b000101};
    r = $urandom_range(0, 9);
    return r < 7 ? ops[r] : 6'($urandom);
  endfunction
  initial begin
    tick();
    tick();
    chk_en = 1'b1;
    #1 ck("rst_zero", 32'(dut_o), 32'd0);
    rst = 1'b0; mr = 1'b1; op = 6'b100011;
    tick();
    #1 ck("lw_c1_fetch", {irwrite, pcwrite, mem_req, iord, alusrcb}, 32'b111001);
    tick();
    #1 ck("lw_c2_decode", {alusrca, alusrcb, aluop}, 32'b01100);
    tick();
    #1 ck("lw_c3_memadr", {alusrca, alusrcb}, 32'b110);
    tick();
    #1 ck("lw_c4_memrd", {mem_req, iord}, 32'b11);
    tick();
    #1 ck("lw_c5_memwb", {regwrite, memtoreg, regdst}, 32'b110);
    tick();
    mr = 1'b0; op = 6'b000100;
    for (int i = 0; i < 3; i++) begin
      #1 ck("fetch_wait", {irwrite, pcwrite, mem_req}, 32'b001);
      tick();
    end
    mr = 1'b1;
    #1 ck("fetch_done", {irwrite, pcwrite}, 32'b11);
    tick();
    tick();
    #1 ck("beq_c3", {pcwrite_cond, pcsrc, aluop}, 32'b10101);
    tick();
    #1 ck("beq_back_fetch", {mem_req, alusrcb}, 32'b101);
    op = 6'h3f;
    tick();
    #1 ck("illegal_pulse", illegal, 1);
    ck("illegal_no_wr", {pcwrite, pcwrite_cond, irwrite, memwrite, regwrite}, 0);
    tick();
    #1 ck("illegal_to_fetch", {mem_req, illegal}, 32'b10);
    op = 6'b000101;
    tick();
`ifdef BNE_EN
    #1 ck("bne_decode_legal", illegal, 0);
    tick();
    #1 ck("bne_branch", {bne_w, pcwrite_cond, pcsrc}, 32'b1101);
    tick();
`else
    #1 ck("bne_illegal", illegal, 1);
    tick();
`endif
    op = 6'b101011;
    tick();
    tick();
    tick();
    mr = 1'b0;
    #1 ck("memwr_wait", {mem_req, iord, memwrite}, 32'b110);
    rst = 1'b1; mr = 1'b1;
    #1 ck("memwr_rst_no_write", memwrite, 0);
    tick();
    #1 ck("memwr_rst_zero", 32'(dut_o), 32'd0);
    rst = 1'b0;
    tick();
    #1 ck("post_rst_fetch", {mem_req, iord, alusrcb, memwrite}, 32'b10010);
    for (int c = 0; c < 4000; c++) begin
      rst = $urandom_range(0, 49) == 0;
      mr = $urandom_range(0, 9) < 6;
      if (m_cur == S_F) op = pick();
      tick();
    end
    rst = 1'b0;
    @(posedge clk);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule

// File: doc/control_fsm.md
CONTROL_FSM -- requirements
Module: control_fsm

Interface
REQ-001 SHALL have parameter OPW, default 6: opcode width in bits.
REQ-002 SHALL have port clk  input  1: single rising-edge clock.
REQ-003 SHALL have port rst  input  1: synchronous, active-high reset.
REQ-004 SHALL have port op  input  OPW: opcode of the current instruction, taken from the instruction register.
REQ-005 SHALL have port mem_ready  input  1: memory has completed the current access.
REQ-006 SHALL have port mem_req  output  1: memory access requested.
REQ-007 SHALL have ports pcwrite, pcwrite_cond, irwrite, memwrite, regwrite  output  1 each: write enables.
REQ-008 SHALL have ports iord, alusrca, regdst, memtoreg  output  1 each: 2-way mux selects.
REQ-009 SHALL have ports alusrcb, pcsrc, aluop  output  2 each: alusrcb and pcsrc drive the 4:1 datapath muxes.
REQ-010 SHALL have port illegal  output  1: one-cycle pulse on an undefined opcode.

Function
REQ-011 SHALL be a Moore FSM with states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP.
REQ-012 SHALL default every output to 0 in every state unless a requirement below asserts it.
REQ-013 SHALL in FETCH assert mem_req, set iord=0, alusrca=0, alusrcb=01, aluop=00 and pcsrc=00, hold the state while mem_ready=0, and assert irwrite and pcwrite only in the cycle mem_ready=1, then move to DECODE.
REQ-014 SHALL in DECODE set alusrca=0, alusrcb=11 and aluop=00 (branch target), then branch on op:
- 100011 or 101011 -> MEMADR
- 000000 -> EXEC
- 000100 -> BRANCH
- 001000 -> ADDIEX
- 000010 -> JUMP
- any other opcode -> FETCH, with illegal=1 for that cycle
REQ-015 SHALL in MEMADR set alusrca=1, alusrcb=10 and aluop=00, then go to MEMRD for lw or MEMWR for sw.
REQ-016 SHALL in MEMRD assert mem_req and iord=1, hold the state until mem_ready=1, then go to MEMWB.
REQ-017 SHALL in MEMWB assert regwrite with regdst=0 and memtoreg=1, then go to FETCH.
REQ-018 SHALL in MEMWR assert mem_req and iord=1, assert memwrite only in the cycle mem_ready=1, and hold the state until then, then go to FETCH.
REQ-019 SHALL in EXEC set alusrca=1, alusrcb=00 and aluop=10, then go to ALUWB.
REQ-020 SHALL in ALUWB assert regwrite with regdst=1 and memtoreg=0, then go to FETCH.
REQ-021 SHALL in BRANCH set alusrca=1, alusrcb=00, aluop=01, pcsrc=01 and pcwrite_cond=1, then go to FETCH.
REQ-022 SHALL in ADDIEX set alusrca=1, alusrcb=10 and aluop=00, then go to ADDIWB.
REQ-023 SHALL in ADDIWB assert regwrite with regdst=0 and memtoreg=0, then go to FETCH.
REQ-024 SHALL in JUMP assert pcwrite with pcsrc=10, then go to FETCH.
REQ-025 SHALL ignore mem_ready in every state other than FETCH, MEMRD and MEMWR.
REQ-026 SHALL take these instruction latencies with zero memory wait: lw 5 cycles; sw, R-type and addi 4 cycles; beq and j 3 cycles.
REQ-027 SHALL never drive pcsrc=11, except under BNE_EN.

Reset
REQ-028 SHALL, when rst=1 at a clock edge, enter FETCH and register all outputs to 0 (registered outputs become FETCH values the cycle after rst falls), from any state including an outstanding memory wait.
REQ-029 SHALL give rst priority over mem_ready and over every transition.

Configuration
REQ-030 SHALL, when BNE_EN is defined, decode op=000101 in DECODE to BRANCH, add output branch_ne (1 bit), and drive branch_ne=1 in BRANCH for bne and branch_ne=0 for beq.
REQ-031 SHALL, when BNE_EN is undefined, omit the branch_ne port and treat op=000101 as illegal.

Structure
REQ-032 SHALL place the state enum, the opcode constants (OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J, OP_BNE), and the alusrcb and pcsrc select encodings in a shared package, mips_ctrl_pkg.
REQ-033 SHALL implement the state-to-outputs decode as one sub-module, ctrl_out_dec, combinational over the state and mem_ready.

Verification
REQ-034 SHALL cover: lw (op=100011), mem_ready=1 always -> FETCH,DECODE,MEMADR,MEMRD,MEMWB; regwrite=1 and memtoreg=1 in cycle 5.
REQ-035 SHALL cover: FETCH with mem_ready held 0 for 3 cycles -> state stays FETCH for 4 cycles, irwrite and pcwrite high only in the 4th cycle.
REQ-036 SHALL cover: beq (000100) -> cycle 3 shows pcwrite_cond=1, pcsrc=01, aluop=01, then FETCH.
REQ-037 SHALL cover: op=111111 -> illegal=1 in DECODE, next state FETCH, no write enable asserted.
REQ-038 SHALL cover: rst=1 during a MEMWR wait -> state FETCH at the next edge, memwrite never asserted.
REQ-039 SHALL cover: with BNE_EN, op=000101 -> BRANCH with branch_ne=1; without BNE_EN, illegal=1.
